// File: rtl/digit_serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared FSM state type and digit-count helper for the adder.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Returns 0 for an illegal WIDTH/DIGIT pairing so the top can flag it.
  function automatic int calc_ndig(input int width, input int digit);
    if (digit < 1 || digit > width || (width % digit) != 0) begin
      return 0;
    end
    return width / digit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_serial_addsub_rca_digit.sv
`default_nettype none
// ============================================================================
// Module   : full_adder / rca_digit
// Purpose  : One-bit full adder and the DIGIT-bit ripple-carry slice built from it.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module rca_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             ci,
  output logic [DIGIT-1:0] s_d,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    full_adder u_fa (
      .a  (a_d[g]),
      .b  (b_d[g]),
      .ci (w_c[g]),
      .s  (s_d[g]),
      .co (w_c[g+1])
    );
  end

  assign co    = w_c[DIGIT];
  // Carry into the top bit; only meaningful on the operand's final digit.
  assign c_msb = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_addsub
// Purpose  : Multi-cycle add/subtract, DIGIT bits per clock, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int c_IW   = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(c_NDIG - 1);

  if (c_NDIG == 0) begin : g_param_err
    $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
  end

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic              r_carry;
  logic [c_IW-1:0]   r_idx;

  logic [DIGIT-1:0]  w_s_d;
  logic              w_co;
  logic              w_cmsb;
  logic [WIDTH-1:0]  w_acc_next;

  rca_digit #(
    .DIGIT (DIGIT)
  ) u_rca (
    .a_d   (r_a[DIGIT-1:0]),
    .b_d   (r_b[DIGIT-1:0]),
    .ci    (r_carry),
    .s_d   (w_s_d),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  // Shift-based form stays legal when DIGIT == WIDTH (single-digit case).
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_s_d) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= sub ? ~b : b;
            r_carry  <= sub ? 1'b1 : cin;
            r_idx    <= '0;
            in_ready <= 1'b0;
            r_state  <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end

        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_acc   <= w_acc_next;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          // Result registers load only once complete, so no partial sum escapes.
          if (r_idx == c_LAST) begin
            sum       <= w_acc_next;
            cout      <= w_co;
            ovf       <= w_co ^ w_cmsb;
            out_valid <= 1'b1;
            r_state   <= HOLD;
          end
        end

        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_addsub
// Purpose  : Directed and randomised checks of digit_serial_addsub at DIGIT = 1, 4, 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  cin_s;
  logic [2:0]  sub_s;
  logic [15:0] a_s [3];
  logic [15:0] b_s [3];
  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  cout_s;
  wire  [2:0]  ovf_s;
  wire  [15:0] sum_s [3];

  int n_checks;
  int n_pass;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int c_D = (g == 0) ? 1 : (g == 1) ? 4 : 16;
    digit_serial_addsub #(
      .WIDTH (16),
      .DIGIT (c_D)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .cin       (cin_s[g]),
      .sub       (sub_s[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum_s[g]),
      .cout      (cout_s[g]),
      .ovf       (ovf_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int ndig_of(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 1;
  endfunction

  // Reference: {ovf, cout, sum}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
    logic [15:0] bb;
    logic [16:0] t;
    logic        v;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {16'd0, (s ? 1'b1 : c)};
    v  = (a[15] == bb[15]) && (t[15] != a[15]);
    return {v, t[16], t[15:0]};
  endfunction

  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input int hold,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input string tag);
    int          n;
    logic [15:0] held;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready[k]) begin
      check({tag, "_ready_timeout"}, in_ready[k], 1);
      return;
    end
    a_s[k] = a; b_s[k] = b; cin_s[k] = c; sub_s[k] = s;
    in_valid[k]  = 1'b1;
    out_ready[k] = (hold == 0);
    @(posedge clk); #1;
    // Scramble inputs while busy; result must depend only on accepted values.
    in_valid[k] = 1'b0;
    a_s[k]   = 16'($urandom);
    b_s[k]   = 16'($urandom);
    cin_s[k] = 1'($urandom);
    sub_s[k] = 1'($urandom);
    n = 0;
    while (!out_valid[k] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, n, ndig_of(k));
    if (!out_valid[k]) return;
    held = sum_s[k];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_sum"}, sum_s[k], held);
      check({tag, "_hold_inrdy"}, in_ready[k], 0);
      check({tag, "_hold_ovalid"}, out_valid[k], 1);
    end
    out_ready[k] = 1'b1;
    check({tag, "_sum"}, sum_s[k], es);
    check({tag, "_cout"}, cout_s[k], ec);
    check({tag, "_ovf"}, ovf_s[k], eo);
    @(posedge clk); #1;
    check({tag, "_ovalid_drop"}, out_valid[k], 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [17:0] m;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '1;
    cin_s     = '0;
    sub_s     = '0;
    for (int i = 0; i < 3; i++) begin
      a_s[i] = '0;
      b_s[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_inrdy", in_ready[1], 0);
    check("rst_ovalid", out_valid[1], 0);
    check("rst_sum", sum_s[1], 0);
    check("rst_cout", cout_s[1], 0);
    check("rst_ovf", ovf_s[1], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_inrdy_rise", in_ready[1], 1);

    run_op(1, 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0, "add");
    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
    run_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0, "wrap");
    run_op(1, 16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    run_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    run_op(1, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 5, 16'h1001, 1'b0, 1'b0, "bp");

    // Abort two cycles into RUN.
    a_s[1] = 16'hAAAA; b_s[1] = 16'h1111; cin_s[1] = 1'b0; sub_s[1] = 1'b0;
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ovalid", out_valid[1], 0);
    check("abort_inrdy", in_ready[1], 0);
    check("abort_sum", sum_s[1], 0);
    check("abort_cout", cout_s[1], 0);
    check("abort_ovf", ovf_s[1], 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_inrdy_rise", in_ready[1], 1);
    run_op(1, 16'h1111, 16'h2222, 1'b1, 1'b0, 0, 16'h3334, 1'b0, 1'b0, "post_rst");

    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1, "d1_ovf");
    run_op(2, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1, "d16_sub");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        m  = model(ra, rb, rc, rs);
        run_op(k, ra, rb, rc, rs, 0, m[15:0], m[16], m[17], "sweep");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
